pipe_ctrl_seq: RTL
==================

Name: pipe_ctrl_seq

Overview:
Registered, pipelined successor to the combinational opcode decoder in the 16-bit pipelined processor. Sits at the ID/EX boundary.
- Decodes each accepted opcode into a control vector and registers it.
- Inserts bubbles for external stalls, branch flushes and multi-cycle floating-point ops.
- Latches a halted state on STOP.
- Drives a ready handshake back to fetch/decode.

Parameters:
- OP_WIDTH, 4, opcode width; encodings below use the low 4 bits, upper bits must be zero or the opcode is illegal.
- CV_WIDTH, 11, control-vector width; must be >= 11; bits above 10 are always 0.
- FP_LAT, 3, issue-occupancy cycles of ADDF/MULTF; legal range 1..15.
- CNT_WIDTH, 16, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- opcode_i  in  OP_WIDTH  opcode from ID stage
- valid_i  in  1  opcode_i holds a real instruction
- flush_i  in  1  taken branch/jump; squash the instruction being offered
- stall_i  in  1  hazard-unit stall (load-use)
- ready_o  out  1  comb.; 1 = decoder accepts valid_i this cycle
- cv_o  out  CV_WIDTH  registered control vector
- fp_busy_o  out  1  registered; FP occupancy in progress
- halted_o  out  1  registered; STOP retired
- illegal_o  out  1  registered one-cycle pulse on an accepted unknown opcode
- instr_cnt_o  out  CNT_WIDTH  retired-instruction count (optional feature)
- stall_cnt_o  out  CNT_WIDTH  bubble-cycle count (optional feature)

Behaviour:
- cv_o bit map (10..0): RegWrite, ALUop, Branch, MemRead, RegDst, MemWrite, Jump, MemToReg, Mov, Floating, Stop.
- Encodings:
  - LW 0000 -> 10011001000
  - SW 0001 -> 00000100000
  - ADD 0010 -> 10000000000
  - MOV 0011 -> 10001000100
  - SUB 0100 -> 11000000000
  - JMPZ 0101 -> 00100000000
  - STOP 0111 -> 00000000001
  - ADDF 1000 -> 10000000010
  - MULTF 1001 -> 10000000010
  - NOP 1111 -> all zero
  - any other value -> all zero, and illegal_o=1 next cycle
- Reset (async, any time, including mid-FP or HALT):
  - state=RUN; cv_o=0; fp_busy_o=0; halted_o=0; illegal_o=0; counters=0; FP counter=0.
- ready_o = (state==RUN) & ~stall_i.
- Accept = valid_i & ready_o & ~flush_i. Latency 1: on the accepting edge, cv_o <= decode(opcode_i). Every non-accepting edge loads cv_o <= 0 (bubble); cv_o never holds a stale value.
- FSM states:
  - RUN: normal issue.
    - Accepted ADDF/MULTF with FP_LAT>1 -> FP_BUSY, fp_cnt<=FP_LAT-1, fp_busy_o<=1.
    - Accepted STOP -> HALT, halted_o<=1.
  - FP_BUSY: ready_o=0, cv_o<=0 each edge, fp_cnt decrements each edge.
    - On the edge where fp_cnt==1 -> RUN, fp_busy_o<=0.
    - ready_o is therefore low for exactly FP_LAT-1 cycles after the FP op issues.
    - flush_i and stall_i are ignored (FP op already issued).
  - HALT: ready_o=0, cv_o=0, halted_o=1. Exit only via rst.
- FP_LAT=1: FP ops never enter FP_BUSY.
- Simultaneous events:
  - flush_i wins over valid_i: STOP, FP or illegal opcodes offered with flush_i are discarded with no state change.
  - stall_i and flush_i together: bubble.
- The Stop bit appears on cv_o for exactly one cycle (the HALT-entry edge).
- illegal_o pulses only on accepted illegal opcodes; an illegal opcode otherwise behaves as NOP.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined:
  - instr_cnt_o increments on every accept with a non-NOP, legal opcode.
  - stall_cnt_o increments on every edge where cv_o is loaded with a bubble while state!=HALT, excluding edges with valid_i=0 in RUN.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
1. Reset, then valid ADD, SUB, LW, SW on consecutive cycles -> cv_o one cycle later = 10000000000, 11000000000, 10011001000, 00000100000; ready_o=1 throughout.
2. FP_LAT=3: MULTF accepted, followed by ADD held valid -> cv_o=10000000010; fp_busy_o=1 and ready_o=0 for 2 cycles with cv_o=0; ADD issues on the 3rd cycle after MULTF.
3. flush_i=1 with valid STOP -> cv_o=0, halted_o stays 0; next cycle STOP without flush -> cv_o=00000000001 for one cycle, then halted_o=1, ready_o=0, and later valid ADDs produce cv_o=0.
4. stall_i=1 for 2 cycles with LW held -> two bubbles (cv_o=0), then LW issues once. PERF_EN: stall_cnt_o=2, instr_cnt_o=1.
5. opcode 0110 valid -> cv_o=0, illegal_o=1 for exactly one cycle, state stays RUN.
6. rst asserted asynchronously mid-FP_BUSY and again in HALT -> all outputs 0 immediately, before the next clk edge; ready_o=1 after release.

Source files
------------

// File: rtl/pipe_ctrl_seq.sv
// Registered ID/EX control sequencer: decodes accepted opcodes and inserts bubbles for stalls, flushes and FP occupancy.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl_seq #(
  parameter int OP_WIDTH  = 4,
  parameter int CV_WIDTH  = 11,
  parameter int FP_LAT    = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_WIDTH-1:0]  opcode_i,
  input  logic                 valid_i,
  input  logic                 flush_i,
  input  logic                 stall_i,
  output logic                 ready_o,
  output logic [CV_WIDTH-1:0]  cv_o,
  output logic                 fp_busy_o,
  output logic                 halted_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] instr_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {RUN, FP_BUSY, HALT} state_t;

  state_t              state, state_next;
  logic [3:0]          fp_cnt, fp_cnt_next;
  logic                accept, legal, is_fp, is_stop;
  logic [10:0]         dec;
  logic [CV_WIDTH-1:0] cv_next;

  assign ready_o = (state == RUN) && !stall_i;
  assign accept  = valid_i && ready_o && !flush_i;

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    dec     = '0;
    is_fp   = 1'b0;
    is_stop = 1'b0;
    // Any set bit above the 4-bit encoding space makes the opcode illegal.
    legal   = (OP_WIDTH'(opcode_i[3:0]) == opcode_i);
    case (opcode_i[3:0])
      4'b0000: dec = 11'b10011001000;
      4'b0001: dec = 11'b00000100000;
      4'b0010: dec = 11'b10000000000;
      4'b0011: dec = 11'b10001000100;
      4'b0100: dec = 11'b11000000000;
      4'b0101: dec = 11'b00100000000;
      4'b0111: begin
        dec     = 11'b00000000001;
        is_stop = 1'b1;
      end
      4'b1000, 4'b1001: begin
        dec   = 11'b10000000010;
        is_fp = 1'b1;
      end
      4'b1111: dec = 11'b00000000000;
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec     = '0;
      is_fp   = 1'b0;
      is_stop = 1'b0;
    end
  end

  always_comb begin
    state_next  = state;
    fp_cnt_next = fp_cnt;
    cv_next     = '0;
    if (accept) cv_next[10:0] = dec;
    case (state)
      RUN: begin
        if (accept && is_stop) begin
          state_next = HALT;
        end else if (accept && is_fp && (FP_LAT > 1)) begin
          state_next  = FP_BUSY;
          fp_cnt_next = 4'(FP_LAT - 1);
        end
      end
      FP_BUSY: begin
        fp_cnt_next = fp_cnt - 4'd1;
        if (fp_cnt == 4'd1) state_next = RUN;
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      fp_cnt    <= '0;
      cv_o      <= '0;
      fp_busy_o <= 1'b0;
      halted_o  <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      state     <= state_next;
      fp_cnt    <= fp_cnt_next;
      cv_o      <= cv_next;
      fp_busy_o <= (state_next == FP_BUSY);
      halted_o  <= (state_next == HALT);
      illegal_o <= accept && !legal;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_WIDTH-1:0] instr_cnt, stall_cnt;
  logic                 instr_inc, stall_inc;

  assign instr_inc = accept && legal && (opcode_i[3:0] != 4'b1111);
  // Idle RUN cycles (no valid instruction offered) are not counted as stalls.
  assign stall_inc = !accept && (state != HALT) && !((state == RUN) && !valid_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (instr_inc && (instr_cnt != '1)) instr_cnt <= instr_cnt + CNT_WIDTH'(1);
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign instr_cnt_o = instr_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign instr_cnt_o = '0;
  assign stall_cnt_o = '0;
`endif

endmodule
